classificador_gestos: RTL and testbench

//  Consumes the debounced button interface (1-cycle press pulse + held level) and

---
 rtl/classificador_gestos_if.sv | 28 ++
 rtl/classificador_gestos.sv | 117 +++++++++++
 tb/tb_classificador_gestos.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/classificador_gestos_if.sv
// Button gesture bundle between debouncer, classifier and menu FSM.
// Master drives the debounced button; slave reports gestures.
interface classificador_gestos_if;
  logic b_pulse;
  logic b_hold;
  logic short_press;
  logic long_press;
  logic double_press;
  logic busy;

  modport master (
    output b_pulse,
    output b_hold,
    input  short_press,
    input  long_press,
    input  double_press,
    input  busy
  );

  modport slave (
    input  b_pulse,
    input  b_hold,
    output short_press,
    output long_press,
    output double_press,
    output busy
  );
endinterface

// File: rtl/classificador_gestos.sv
// Classifies debounced button activity as short, long or double press.
// One registered 1-cycle pulse per recognised gesture.
module classificador_gestos #(
  parameter int LONG_CYCLES = 25_000_000,
  parameter int DOUBLE_GAP  = 12_500_000,
  parameter int CNT_W       = 25
) (
  input logic clk,
  input logic rst,
  classificador_gestos_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESSED1,
    S_LONG_HELD,
    S_WAIT2,
    S_PRESSED2
  } state_t;

  localparam logic [CNT_W-1:0] C_LONG_END =
    CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_GAP_END =
    CNT_W'(DOUBLE_GAP - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_short;
  logic             r_long;
  logic             r_double;
  logic             w_short_nxt;
  logic             w_long_nxt;
  logic             w_double_nxt;

  // State, counter and gesture pulses, all cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_double <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_short  <= w_short_nxt;
      r_long   <= w_long_nxt;
      r_double <= w_double_nxt;
    end
  end

  // Next state; release beats timeout, second press beats gap expiry.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_short_nxt  = 1'b0;
    w_long_nxt   = 1'b0;
    w_double_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.b_pulse) begin
          w_state_nxt = S_PRESSED1;
          w_cnt_nxt   = '0;
        end
      end
      S_PRESSED1: begin
        if (!bus.b_hold) begin
          w_state_nxt = S_WAIT2;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_LONG_END) begin
          w_long_nxt  = 1'b1;
          w_state_nxt = S_LONG_HELD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_LONG_HELD: begin
        if (!bus.b_hold) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      S_WAIT2: begin
        if (bus.b_pulse) begin
          w_double_nxt = 1'b1;
          w_state_nxt  = S_PRESSED2;
          w_cnt_nxt    = '0;
        end else if (r_cnt == C_GAP_END) begin
          w_short_nxt = 1'b1;
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_PRESSED2: begin
        if (!bus.b_hold) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.short_press  = r_short;
  assign bus.long_press   = r_long;
  assign bus.double_press = r_double;
  assign bus.busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_classificador_gestos.sv
// Scoreboard bench for the gesture classifier.
// Expected pulses are queued at stimulus time, matched on output.
module tb_classificador_gestos;

  localparam logic [2:0] K_SHORT  = 3'b001;
  localparam logic [2:0] K_LONG   = 3'b010;
  localparam logic [2:0] K_DOUBLE = 3'b100;

  typedef struct {
    int         edge_n;
    logic [2:0] kind;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   ecount = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   n_short = 0;
  exp_t sb[$];
  exp_t e;
  logic [2:0] obs;

  classificador_gestos_if bif();

  classificador_gestos #(
    .LONG_CYCLES(8),
    .DOUBLE_GAP (5),
    .CNT_W      (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ecount <= ecount + 1;

  // Match every observed gesture pulse against the scoreboard.
  always @(negedge clk) begin
    obs = {bif.double_press, bif.long_press, bif.short_press};
    if (!rst && obs != 3'b000) begin
      n_total++;
      if (obs == K_SHORT) n_short++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_pulse: got %b at edge %0d, expected none",
                 obs, ecount);
      end else begin
        e = sb.pop_front();
        if (obs !== e.kind || ecount !== e.edge_n)
          $display("FAIL pulse: got %b at edge %0d, expected %b at edge %0d",
                   obs, ecount, e.kind, e.edge_n);
        else
          n_pass++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int en, input logic [2:0] k);
    exp_t x;
    x.edge_n = en;
    x.kind   = k;
    sb.push_back(x);
  endtask

  // Press sampled next edge (P0), held through P0+2, released at P0+3.
  task automatic drive_short(output int p0);
    bif.b_pulse = 1'b1;
    bif.b_hold  = 1'b1;
    tick(1);
    p0 = ecount;
    bif.b_pulse = 1'b0;
    tick(2);
    bif.b_hold = 1'b0;
    push(p0 + 8, K_SHORT);
  endtask

  task automatic test_reset;
    bif.b_pulse = 1'b0;
    bif.b_hold  = 1'b0;
    rst = 1'b1;
    tick(3);
    n_total++;
    if ({bif.busy, bif.double_press, bif.long_press,
         bif.short_press} !== 4'b0000)
      $display("FAIL reset_outputs: got %b, expected 0000",
               {bif.busy, bif.double_press, bif.long_press,
                bif.short_press});
    else n_pass++;
    rst = 1'b0;
    tick(2);
    n_total++;
    if (bif.busy !== 1'b0)
      $display("FAIL reset_idle_busy: got %b, expected 0", bif.busy);
    else n_pass++;
  endtask

  task automatic test_short;
    int p0;
    drive_short(p0);
    n_total++;
    if (bif.busy !== 1'b1)
      $display("FAIL short_busy_early: got %b, expected 1", bif.busy);
    else n_pass++;
    tick(5);
    n_total++;
    if (bif.busy !== 1'b1)
      $display("FAIL short_busy_late: got %b, expected 1", bif.busy);
    else n_pass++;
    tick(1);
    n_total++;
    if (bif.busy !== 1'b0)
      $display("FAIL short_busy_end: got %b, expected 0", bif.busy);
    else n_pass++;
    tick(4);
    n_total++;
    if (sb.size() != 0)
      $display("FAIL short_missing: %0d pending, expected 0", sb.size());
    else n_pass++;
    sb.delete();
  endtask

  task automatic test_long;
    int p0;
    bif.b_pulse = 1'b1;
    bif.b_hold  = 1'b1;
    tick(1);
    p0 = ecount;
    bif.b_pulse = 1'b0;
    push(p0 + 8, K_LONG);
    tick(10);
    bif.b_pulse = 1'b1;
    tick(1);
    bif.b_pulse = 1'b0;
    tick(9);
    n_total++;
    if (bif.busy !== 1'b1)
      $display("FAIL long_held_busy: got %b, expected 1", bif.busy);
    else n_pass++;
    bif.b_hold = 1'b0;
    tick(1);
    n_total++;
    if (bif.busy !== 1'b0)
      $display("FAIL long_release_idle: got %b, expected 0", bif.busy);
    else n_pass++;
    tick(10);
    n_total++;
    if (sb.size() != 0)
      $display("FAIL long_missing: %0d pending, expected 0", sb.size());
    else n_pass++;
    sb.delete();
  endtask

  task automatic test_double;
    int p0;
    bif.b_pulse = 1'b1;
    bif.b_hold  = 1'b1;
    tick(1);
    p0 = ecount;
    bif.b_pulse = 1'b0;
    tick(1);
    bif.b_hold = 1'b0;
    tick(3);
    bif.b_pulse = 1'b1;
    bif.b_hold  = 1'b1;
    push(p0 + 5, K_DOUBLE);
    tick(1);
    bif.b_pulse = 1'b0;
    tick(2);
    n_total++;
    if (bif.busy !== 1'b1)
      $display("FAIL double_hold_busy: got %b, expected 1", bif.busy);
    else n_pass++;
    bif.b_hold = 1'b0;
    tick(1);
    n_total++;
    if (bif.busy !== 1'b0)
      $display("FAIL double_release_idle: got %b, expected 0", bif.busy);
    else n_pass++;
    tick(8);
    n_total++;
    if (sb.size() != 0)
      $display("FAIL double_missing: %0d pending, expected 0", sb.size());
    else n_pass++;
    sb.delete();
  endtask

  task automatic test_ties;
    int p0;
    bif.b_pulse = 1'b1;
    bif.b_hold  = 1'b1;
    tick(1);
    p0 = ecount;
    bif.b_pulse = 1'b0;
    bif.b_hold  = 1'b0;
    tick(5);
    bif.b_pulse = 1'b1;
    bif.b_hold  = 1'b1;
    push(p0 + 6, K_DOUBLE);
    tick(1);
    bif.b_pulse = 1'b0;
    tick(1);
    bif.b_hold = 1'b0;
    tick(8);
    n_total++;
    if (sb.size() != 0)
      $display("FAIL tie_double: %0d pending, expected 0", sb.size());
    else n_pass++;
    sb.delete();
    bif.b_pulse = 1'b1;
    bif.b_hold  = 1'b1;
    tick(1);
    p0 = ecount;
    bif.b_pulse = 1'b0;
    tick(7);
    bif.b_hold = 1'b0;
    push(p0 + 13, K_SHORT);
    tick(16);
    n_total++;
    if (sb.size() != 0)
      $display("FAIL tie_long: %0d pending, expected 0", sb.size());
    else n_pass++;
    sb.delete();
  endtask

  task automatic test_reset_mid;
    int p0;
    bif.b_pulse = 1'b1;
    bif.b_hold  = 1'b1;
    tick(1);
    bif.b_pulse = 1'b0;
    tick(2);
    rst = 1'b1;
    #1;
    n_total++;
    if ({bif.busy, bif.double_press, bif.long_press,
         bif.short_press} !== 4'b0000)
      $display("FAIL midreset_outputs: got %b, expected 0000",
               {bif.busy, bif.double_press, bif.long_press,
                bif.short_press});
    else n_pass++;
    tick(1);
    rst = 1'b0;
    tick(14);
    n_total++;
    if (bif.busy !== 1'b0)
      $display("FAIL midreset_ignore_hold: got %b, expected 0", bif.busy);
    else n_pass++;
    bif.b_hold = 1'b0;
    tick(8);
    drive_short(p0);
    tick(10);
    n_total++;
    if (sb.size() != 0)
      $display("FAIL midreset_fresh: %0d pending, expected 0", sb.size());
    else n_pass++;
    sb.delete();
  endtask

  task automatic test_back_to_back;
    int p0;
    int s0;
    s0 = n_short;
    for (int i = 0; i < 3; i++) begin
      drive_short(p0);
      tick(12);
    end
    n_total++;
    if (n_short - s0 !== 3)
      $display("FAIL b2b_count: got %0d shorts, expected 3", n_short - s0);
    else n_pass++;
    n_total++;
    if (sb.size() != 0)
      $display("FAIL b2b_missing: %0d pending, expected 0", sb.size());
    else n_pass++;
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_double();
    test_ties();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
